note_judge: RTL and testbench

NOTE_JUDGE -- requirements
Module: note_judge

---
 rtl/note_judge.sv | 146 ++++++++++++++
 tb/tb_note_judge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_judge.sv
// note_judge: per-lane hit/miss judge for a three-drum rhythm game.
//
// Each lane sees a 27-bit note window; bit 26 is the oldest note (leaves on
// the next shift), bit 25 the next one. A rising edge on a drum button is a
// press. A press hits the bit-26 note as GREAT if unconsumed, otherwise the
// bit-25 note as GOOD if unconsumed, otherwise it does nothing. On tick the
// windows shift: an unconsumed bit-26 note becomes a MISS and the consumed
// flags move down one position.
//
// Ports:
//   clk                                 system clock, posedge
//   reset                               synchronous, active-high
//   tick                                last cycle before the windows shift
//   loading                             song being loaded; judge held idle
//   lane_red/lane_blue/lane_yellow[26:0] visible note windows
//   btn_red/btn_blue/btn_yellow         synchronized drum button levels
//   score[15:0]                         accumulated score, saturating
//   combo[7:0]                          consecutive hits, saturating
//   max_combo[7:0]                      highest combo since last clear
//   great/good/miss                     one-cycle event pulses
module note_judge (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        loading,
   input  logic [26:0] lane_red,
   input  logic [26:0] lane_blue,
   input  logic [26:0] lane_yellow,
   input  logic        btn_red,
   input  logic        btn_blue,
   input  logic        btn_yellow,
   output logic [15:0] score,
   output logic [7:0]  combo,
   output logic [7:0]  max_combo,
   output logic        great,
   output logic        good,
   output logic        miss
);

   // Lane vectors are ordered {yellow, blue, red}.
   logic [2:0]  btn_prev_q, btn_prev_d;
   logic [2:0]  c26_q, c26_d;
   logic [2:0]  c25_q, c25_d;
   logic [15:0] score_q, score_d;
   logic [7:0]  combo_q, combo_d;
   logic [7:0]  max_combo_q, max_combo_d;
   logic        great_q, great_d;
   logic        good_q, good_d;
   logic        miss_q, miss_d;

   logic [2:0]  btn, bit26, bit25, press;
   logic [2:0]  hit_great, hit_good, c26_hit, c25_hit, lane_miss;
   logic [1:0]  n_great, n_good, n_hit;
   logic [10:0] score_inc;
   logic [16:0] score_sum;
   logic [8:0]  combo_sum;

   // Only the two oldest window positions matter to the judge.
   logic unused_lane_bits;
   assign unused_lane_bits = ^{lane_red[24:0], lane_blue[24:0], lane_yellow[24:0]};

   assign btn   = {btn_yellow, btn_blue, btn_red};
   assign bit26 = {lane_yellow[26], lane_blue[26], lane_red[26]};
   assign bit25 = {lane_yellow[25], lane_blue[25], lane_red[25]};
   assign press = btn & ~btn_prev_q;

   // Press is judged against the current window before the tick rules apply,
   // so a note hit in the tick cycle is never also counted as a miss.
   assign hit_great = press & bit26 & ~c26_q;
   assign hit_good  = press & ~hit_great & bit25 & ~c25_q;
   assign c26_hit   = c26_q | hit_great;
   assign c25_hit   = c25_q | hit_good;
   assign lane_miss = {3{tick}} & bit26 & ~c26_hit;

   // A lane scores at most one hit per cycle, so every count fits 2 bits.
   assign n_great = {1'b0, hit_great[0]} + {1'b0, hit_great[1]} + {1'b0, hit_great[2]};
   assign n_good  = {1'b0, hit_good[0]} + {1'b0, hit_good[1]} + {1'b0, hit_good[2]};
   assign n_hit   = {1'b0, hit_great[0] | hit_good[0]}
                  + {1'b0, hit_great[1] | hit_good[1]}
                  + {1'b0, hit_great[2] | hit_good[2]};

   assign score_inc = ({9'd0, n_great} * 11'd300) + ({9'd0, n_good} * 11'd100);
   assign score_sum = {1'b0, score_q} + {6'd0, score_inc};
   assign combo_sum = {1'b0, combo_q} + {7'd0, n_hit};

   always_comb begin
      btn_prev_d  = btn;
      c26_d       = tick ? c25_hit : c26_hit;
      c25_d       = tick ? 3'b000  : c25_hit;
      score_d     = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      combo_d     = combo_sum[8]  ? 8'hFF    : combo_sum[7:0];
      if (|lane_miss) begin
         combo_d = 8'd0;
      end
      max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
      great_d     = |hit_great;
      good_d      = |hit_good;
      miss_d      = |lane_miss;

      // While loading the judge is idle and cleared; button history still
      // tracks so a button held across the end of loading is not a press.
      if (loading) begin
         c26_d       = 3'b000;
         c25_d       = 3'b000;
         score_d     = 16'd0;
         combo_d     = 8'd0;
         max_combo_d = 8'd0;
         great_d     = 1'b0;
         good_d      = 1'b0;
         miss_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // Clearing btn_prev makes a button held through reset a new press.
         btn_prev_q  <= 3'b000;
         c26_q       <= 3'b000;
         c25_q       <= 3'b000;
         score_q     <= 16'd0;
         combo_q     <= 8'd0;
         max_combo_q <= 8'd0;
         great_q     <= 1'b0;
         good_q      <= 1'b0;
         miss_q      <= 1'b0;
      end else begin
         btn_prev_q  <= btn_prev_d;
         c26_q       <= c26_d;
         c25_q       <= c25_d;
         score_q     <= score_d;
         combo_q     <= combo_d;
         max_combo_q <= max_combo_d;
         great_q     <= great_d;
         good_q      <= good_d;
         miss_q      <= miss_d;
      end
   end

   assign score     = score_q;
   assign combo     = combo_q;
   assign max_combo = max_combo_q;
   assign great     = great_q;
   assign good      = good_q;
   assign miss      = miss_q;

endmodule

// File: tb/tb_note_judge.sv
module tb_note_judge;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, tick, loading;
   logic [26:0] lane_red, lane_blue, lane_yellow;
   logic        btn_red, btn_blue, btn_yellow;
   logic [15:0] score;
   logic [7:0]  combo, max_combo;
   logic        great, good, miss;

   note_judge dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .loading    (loading),
      .lane_red   (lane_red),
      .lane_blue  (lane_blue),
      .lane_yellow(lane_yellow),
      .btn_red    (btn_red),
      .btn_blue   (btn_blue),
      .btn_yellow (btn_yellow),
      .score      (score),
      .combo      (combo),
      .max_combo  (max_combo),
      .great      (great),
      .good       (good),
      .miss       (miss)
   );

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The song is a list of note slots per lane; window bit 26 shows slot
   // 'base', bit 25 shows slot base+1, and every tick advances base.
   // Judged notes are remembered by slot identity.
   bit        song [3][0:4095];
   int        base = 0;
   bit        judged [int];
   int        m_score, m_combo, m_max;
   bit        m_great, m_good, m_miss;
   bit [2:0]  m_prev;
   logic [34:0] exp_q[$];

   function automatic int slot_key(int slot, int l);
      return slot * 4 + l;
   endfunction

   task automatic model_step(input bit t, input bit ld, input bit rs, input bit [2:0] b);
      int ng, nd;
      bit any_miss;
      ng = 0; nd = 0; any_miss = 0;
      if (rs) begin
         m_score = 0; m_combo = 0; m_max = 0;
         m_great = 0; m_good = 0; m_miss = 0;
         m_prev = 3'b000;
         judged.delete();
      end else if (ld) begin
         m_score = 0; m_combo = 0; m_max = 0;
         m_great = 0; m_good = 0; m_miss = 0;
         m_prev = b;
         judged.delete();
      end else begin
         for (int l = 0; l < 3; l++) begin
            if (b[l] && !m_prev[l]) begin
               if (song[l][base] && !judged.exists(slot_key(base, l))) begin
                  ng++;
                  judged[slot_key(base, l)] = 1'b1;
               end else if (song[l][base+1] && !judged.exists(slot_key(base+1, l))) begin
                  nd++;
                  judged[slot_key(base+1, l)] = 1'b1;
               end
            end
            if (t && song[l][base] && !judged.exists(slot_key(base, l)))
               any_miss = 1'b1;
         end
         m_score = m_score + 300 * ng + 100 * nd;
         if (m_score > 65535) m_score = 65535;
         if (any_miss) m_combo = 0;
         else begin
            m_combo = m_combo + ng + nd;
            if (m_combo > 255) m_combo = 255;
         end
         if (m_combo > m_max) m_max = m_combo;
         m_great = (ng > 0);
         m_good  = (nd > 0);
         m_miss  = any_miss;
         m_prev  = b;
      end
      exp_q.push_back({m_score[15:0], m_combo[7:0], m_max[7:0], m_great, m_good, m_miss});
   endtask

   task automatic compare_outputs();
      logic [34:0] e;
      if (exp_q.size() == 0) begin
         check_val("exp_queue_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_val("score", {16'd0, score}, {16'd0, e[34:19]});
         check_val("combo", {24'd0, combo}, {24'd0, e[18:11]});
         check_val("max_combo", {24'd0, max_combo}, {24'd0, e[10:3]});
         check_val("great", {31'd0, great}, {31'd0, e[2]});
         check_val("good", {31'd0, good}, {31'd0, e[1]});
         check_val("miss", {31'd0, miss}, {31'd0, e[0]});
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive_windows();
      for (int k = 0; k < 27; k++) begin
         lane_red[k]    = song[0][base + 26 - k];
         lane_blue[k]   = song[1][base + 26 - k];
         lane_yellow[k] = song[2][base + 26 - k];
      end
   endtask

   task automatic cycle(input bit t, input bit ld, input bit rs, input bit [2:0] b);
      @(negedge clk);
      drive_windows();
      tick = t; loading = ld; reset = rs;
      {btn_yellow, btn_blue, btn_red} = b;
      @(posedge clk);
      model_step(t, ld, rs, b);
      if (t) base++;
      #1;
      compare_outputs();
   endtask

   task automatic clear_song(input int from, input int len);
      for (int s = from; s < from + len; s++)
         for (int l = 0; l < 3; l++) song[l][s] = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int s = 0; s < 4096; s++)
         for (int l = 0; l < 3; l++) song[l][s] = 1'($urandom_range(0, 1));
      reset = 1'b1; tick = 1'b0; loading = 1'b0;
      btn_red = 1'b0; btn_blue = 1'b0; btn_yellow = 1'b0;
      drive_windows();

      cycle(0, 0, 1, 3'b000);
      cycle(0, 0, 1, 3'b000);
      check_val("rst_score", {16'd0, score}, 32'd0);
      check_val("rst_combo", {24'd0, combo}, 32'd0);
      check_val("rst_pulses", {29'd0, great, good, miss}, 32'd0);

      // Single GREAT on red, then a repeat press before tick does nothing.
      clear_song(base, 40);
      song[0][base] = 1'b1;
      cycle(0, 0, 0, 3'b000);
      cycle(0, 0, 0, 3'b001);
      check_val("great_first", {31'd0, great}, 32'd1);
      check_val("great_score", {16'd0, score}, 32'd300);
      check_val("great_combo", {24'd0, combo}, 32'd1);
      cycle(0, 0, 0, 3'b000);
      cycle(0, 0, 0, 3'b001);
      check_val("repress_score", {16'd0, score}, 32'd300);
      check_val("repress_great", {31'd0, great}, 32'd0);

      // Red hit on the tick cycle while yellow misses in the same cycle.
      cycle(1, 0, 0, 3'b000);
      song[0][base] = 1'b1;
      song[2][base] = 1'b1;
      cycle(1, 0, 0, 3'b001);
      check_val("tick_hit_great", {31'd0, great}, 32'd1);
      check_val("tick_hit_miss", {31'd0, miss}, 32'd1);
      check_val("tick_hit_combo", {24'd0, combo}, 32'd0);
      check_val("tick_hit_score", {16'd0, score}, 32'd600);

      // Three-lane GREAT rounds until score and combo saturate.
      for (int s = base; s < base + 200; s++)
         for (int l = 0; l < 3; l++) song[l][s] = 1'b1;
      cycle(0, 0, 0, 3'b000);
      for (int r = 0; r < 90; r++) begin
         cycle(0, 0, 0, 3'b111);
         cycle(1, 0, 0, 3'b000);
      end
      check_val("sat_score", {16'd0, score}, 32'd65535);
      check_val("sat_combo", {24'd0, combo}, 32'd255);
      check_val("sat_max", {24'd0, max_combo}, 32'd255);

      // Loading clears everything; reset with red held gives a press after.
      cycle(0, 1, 0, 3'b000);
      check_val("load_score", {16'd0, score}, 32'd0);
      check_val("load_max", {24'd0, max_combo}, 32'd0);
      cycle(0, 0, 1, 3'b001);
      cycle(0, 0, 0, 3'b001);
      check_val("held_reset_great", {31'd0, great}, 32'd1);
      check_val("held_reset_score", {16'd0, score}, 32'd300);

      // GOOD on bit 25, carried flag blocks both re-hit and miss.
      cycle(0, 0, 0, 3'b000);
      clear_song(base, 40);
      song[1][base+1] = 1'b1;
      cycle(0, 0, 0, 3'b010);
      check_val("good_pulse", {31'd0, good}, 32'd1);
      check_val("good_score", {16'd0, score}, 32'd400);
      cycle(1, 0, 0, 3'b000);
      cycle(0, 0, 0, 3'b010);
      check_val("carried_score", {16'd0, score}, 32'd400);
      cycle(1, 0, 0, 3'b000);
      check_val("carried_no_miss", {31'd0, miss}, 32'd0);
      check_val("carried_combo", {24'd0, combo}, 32'd2);

      // Unhit yellow note at tick: miss, combo cleared, max kept.
      song[2][base] = 1'b1;
      cycle(1, 0, 0, 3'b000);
      check_val("miss_pulse", {31'd0, miss}, 32'd1);
      check_val("miss_combo", {24'd0, combo}, 32'd0);
      check_val("miss_max", {24'd0, max_combo}, 32'd2);
      check_val("miss_score", {16'd0, score}, 32'd400);

      // Random play against the slot-based model.
      for (int s = base; s < 4096; s++)
         for (int l = 0; l < 3; l++) song[l][s] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 1200; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0,
               $urandom_range(0, 149) == 0, 3'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
